// File: rtl/beta_pkg.sv
// Shared Beta pipeline definitions: write-back state encoding, default widths
// and instruction field positions.
package beta_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RETIRE  = 2'd1,
        WAIT_LD = 2'd2
    } wb_state_t;

    localparam int XLEN_DEF     = 32;
    localparam int ZERO_REG_DEF = 31;
    localparam int IR_W         = 32;
    localparam int OPC_MSB      = 31;
    localparam int RC_MSB       = 25;
    localparam int RC_LSB       = 21;

endpackage

// File: rtl/wb_stage_if.sv
// MEM-to-WB handshake/datapath bundle plus the register-file write port and
// the load bypass/hazard signals returned to decode.
interface wb_stage_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] pc;
    logic [31:0]     ir;
    logic [XLEN-1:0] y;
    logic            op_ld;
    logic            op_st;
    logic            op_jump;
    logic            mem_rd_valid;
    logic [XLEN-1:0] mem_rd;
    logic            rf_we;
    logic [RA_W-1:0] rf_w_addr;
    logic [XLEN-1:0] rf_w_data;
    logic            byp_pending;
    logic [RA_W-1:0] byp_pend_addr;

    modport master (
        output in_valid, pc, ir, y, op_ld, op_st, op_jump, mem_rd_valid, mem_rd,
        input  in_ready, rf_we, rf_w_addr, rf_w_data, byp_pending, byp_pend_addr
    );

    modport slave (
        input  in_valid, pc, ir, y, op_ld, op_st, op_jump, mem_rd_valid, mem_rd,
        output in_ready, rf_we, rf_w_addr, rf_w_data, byp_pending, byp_pend_addr
    );
endinterface

// File: rtl/wb_ld_timer.sv
// Saturating wait counter for outstanding loads; expired is high once the
// count has reached LD_TIMEOUT.
module wb_ld_timer #(
    parameter int LD_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int TW = (LD_TIMEOUT < 1) ? 1 : $clog2(LD_TIMEOUT + 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    assign expired = (cnt_q == TW'(LD_TIMEOUT));

    // Next count: clear wins, then count up until saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {TW{1'b0}};
        end else if (en && !expired) begin
            cnt_d = cnt_q + TW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {TW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/wb_stage.sv
// Beta write-back stage: registers MEM results under valid/ready, waits for
// late load data with a timeout, and drives the RF write port and bypass info.
module wb_stage
    import beta_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int RA_W       = 5,
    parameter int ZERO_REG   = ZERO_REG_DEF,
    parameter int LD_TIMEOUT = 15,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    wb_stage_if.slave        bus,
    output logic [IR_W-1:0]  ir_next,
    output logic [CNT_W-1:0] retire_count,
    output logic             mem_err
);
    localparam logic [RA_W-1:0] ZERO_ADDR = RA_W'(ZERO_REG);

    wb_state_t        state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [IR_W-1:0]  ir_q, ir_d;
    logic [XLEN-1:0]  y_q, y_d;
    logic             op_ld_q, op_ld_d;
    logic             op_st_q, op_st_d;
    logic             op_jump_q, op_jump_d;
    logic [XLEN-1:0]  ld_data_q, ld_data_d;
    logic [CNT_W-1:0] retire_count_q, retire_count_d;
    logic             mem_err_q, mem_err_d;

    logic             in_ready_s;
    logic             transfer_s;
    logic             tmr_expired_s;
    logic [RA_W-1:0]  rc_s;

    assign in_ready_s = (state_q != WAIT_LD);
    assign transfer_s = bus.in_valid && in_ready_s;
    assign rc_s       = ir_q[RC_LSB +: RA_W];

    wb_ld_timer #(
        .LD_TIMEOUT (LD_TIMEOUT)
    ) u_ld_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q != WAIT_LD),
        .en      ((state_q == WAIT_LD) && !bus.mem_rd_valid),
        .expired (tmr_expired_s)
    );

    // Next-state and stage-register capture.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ir_d           = ir_q;
        y_d            = y_q;
        op_ld_d        = op_ld_q;
        op_st_d        = op_st_q;
        op_jump_d      = op_jump_q;
        ld_data_d      = ld_data_q;
        mem_err_d      = mem_err_q;
        retire_count_d = retire_count_q;

        if (state_q == RETIRE) begin
            retire_count_d = retire_count_q + CNT_W'(1);
        end else begin
            retire_count_d = retire_count_q;
        end

        case (state_q)
            IDLE, RETIRE: begin
                if (transfer_s) begin
                    pc_d      = bus.pc;
                    ir_d      = bus.ir;
                    y_d       = bus.y;
                    op_ld_d   = bus.op_ld;
                    op_st_d   = bus.op_st;
                    op_jump_d = bus.op_jump;
                    if (!bus.op_ld) begin
                        state_d = RETIRE;
                    end else if (bus.mem_rd_valid) begin
                        ld_data_d = bus.mem_rd;
                        state_d   = RETIRE;
                    end else begin
                        state_d = WAIT_LD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            // Data arriving in the final timer cycle still completes the load.
            WAIT_LD: begin
                if (bus.mem_rd_valid) begin
                    ld_data_d = bus.mem_rd;
                    state_d   = RETIRE;
                end else if (tmr_expired_s) begin
                    mem_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = WAIT_LD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stage registers, retire counter and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            pc_q           <= {XLEN{1'b0}};
            ir_q           <= {IR_W{1'b0}};
            y_q            <= {XLEN{1'b0}};
            op_ld_q        <= 1'b0;
            op_st_q        <= 1'b0;
            op_jump_q      <= 1'b0;
            ld_data_q      <= {XLEN{1'b0}};
            retire_count_q <= {CNT_W{1'b0}};
            mem_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            ir_q           <= ir_d;
            y_q            <= y_d;
            op_ld_q        <= op_ld_d;
            op_st_q        <= op_st_d;
            op_jump_q      <= op_jump_d;
            ld_data_q      <= ld_data_d;
            retire_count_q <= retire_count_d;
            mem_err_q      <= mem_err_d;
        end
    end

    // Write-data select and bypass address, decoded from stage registers.
    always_comb begin
        bus.rf_w_data     = y_q;
        bus.byp_pend_addr = {RA_W{1'b0}};
        if (op_ld_q) begin
            bus.rf_w_data = ld_data_q;
        end else if (op_jump_q) begin
            bus.rf_w_data = pc_q;
        end else begin
            bus.rf_w_data = y_q;
        end
        if (bus.byp_pending) begin
            bus.byp_pend_addr = rc_s;
        end else begin
            bus.byp_pend_addr = {RA_W{1'b0}};
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.rf_we       = (state_q == RETIRE) && !op_st_q && (rc_s != ZERO_ADDR);
    assign bus.rf_w_addr   = rc_s;
    assign bus.byp_pending = (state_q == WAIT_LD) && (rc_s != ZERO_ADDR);
    assign ir_next         = ir_q;
    assign retire_count    = retire_count_q;
    assign mem_err         = mem_err_q;
endmodule

// File: doc/wb_stage.md
# wb_stage

Parametrised write-back stage for the Beta pipeline, the successor to the fixed single-cycle write-back stage. It registers the incoming MEM-stage result under a valid/ready handshake and supports multi-cycle load data return with a timeout. It drives register-file write port signals, a bypass/hazard interface back to decode, and a retired-instruction counter. It sits between the memory stage and the register file.

## Interface
Parameters:
- XLEN, 32, datapath width of pc, y, mem_rd and rf_w_data.
- RA_W, 5, register address width.
- ZERO_REG, 31, hardwired-zero register; writes to it are suppressed.
- LD_TIMEOUT, 15, maximum WAIT_LD cycles before the load is abandoned; must be at least 1.
- CNT_W, 32, retire counter width.

Ports:
- Clock and reset (one clock; reset is asynchronous and active-high):
  - clk  in  1  clock.
  - rst  in  1  reset.
- Input handshake and datapath:
  - in_valid  in  1  MEM stage presents an instruction.
  - in_ready  out  1  stage accepts this cycle.
  - pc  in  XLEN  return address (already PC+4).
  - ir  in  32  instruction; rc = ir[25:21] (low RA_W bits).
  - y  in  XLEN  ALU result.
  - op_ld  in  1  LD/LDR.
  - op_st  in  1  ST (no write).
  - op_jump  in  1  JMP/BR (write pc).
- Memory read return:
  - mem_rd_valid  in  1  load data valid.
  - mem_rd  in  XLEN  load data.
- Register-file write port:
  - rf_we  out  1  register-file write enable.
  - rf_w_addr  out  RA_W  write address.
  - rf_w_data  out  XLEN  write data.
- Hazard and bypass interface:
  - byp_pending  out  1  a load to byp_pend_addr is outstanding.
  - byp_pend_addr  out  RA_W  destination of the outstanding load.
- Status:
  - ir_next  out  32  retiring instruction, for trace.
  - retire_count  out  CNT_W  instructions retired.
  - mem_err  out  1  sticky load-timeout flag.

## Operation
- A transfer occurs when in_valid && in_ready; the stage captures pc, ir, y and the op flags.
- in_ready = (state != WAIT_LD).
- State machine (wb_state_t):
  - IDLE
    - On transfer: non-load -> RETIRE.
    - On transfer: load with mem_rd_valid=1 in the same cycle -> capture mem_rd, go to RETIRE.
    - On transfer: load otherwise -> WAIT_LD, timer=0.
  - WAIT_LD
    - mem_rd_valid=1 -> capture mem_rd, go to RETIRE.
    - Otherwise the timer increments.
    - When the timer reaches LD_TIMEOUT with no data: set mem_err, drop the instruction with no write and no count, go to IDLE.
  - RETIRE
    - The instruction retires this cycle.
    - New transfer -> same decisions as IDLE (back-to-back, zero bubbles).
    - No transfer -> IDLE.
- mem_rd_valid outside WAIT_LD and outside a load-accept cycle is ignored.
- Write-data select, combinational from stage registers, priority ld > jump > ALU:
  - op_ld -> captured load data.
  - op_jump -> pc.
  - else -> y.
- rf_we = (state==RETIRE) && !op_st && rf_w_addr != ZERO_REG.
  - op_st together with any other flag -> no write.
- rf_w_addr = captured rc; ir_next = captured ir.
- Bypass interface:
  - byp_pending = (state==WAIT_LD) && rc != ZERO_REG.
  - byp_pend_addr = rc when byp_pending is 1, otherwise 0.
- retire_count increments by 1 in every RETIRE cycle, stores included; it wraps modulo 2^CNT_W.
- mem_err is cleared only by rst.

## Timing
- Non-load, or load with same-cycle data: accepted at edge N; rf_we is high in the cycle after edge N; the RF writes at edge N+1.
- Load with data k cycles after accept (1 ≤ k ≤ LD_TIMEOUT): rf_we is high in the cycle following the edge at which data is captured.
  - Total latency is k+1 cycles.
  - in_ready is low for k cycles.
- Timeout: mem_err is high starting LD_TIMEOUT+1 cycles after accept; in_ready returns high in the same cycle.
- Throughput is one instruction per cycle when there are no load waits.
- Reset (asynchronous, any state, including mid-WAIT_LD):
  - state=IDLE, stage registers=0, timer=0.
  - rf_we=0, rf_w_addr=0, rf_w_data=0, ir_next=0.
  - byp_pending=0, byp_pend_addr=0, retire_count=0, mem_err=0.
  - in_ready=1 while rst is asserted.
  - A pending load is discarded.

## Structure
- Shared package beta_pkg holds:
  - wb_state_t enum (IDLE, RETIRE, WAIT_LD).
  - Default constants XLEN_DEF=32 and ZERO_REG_DEF=31.
  - Opcode field positions (OPC_MSB=31, RC_MSB=25, RC_LSB=21).
- One sub-module, wb_ld_timer:
  - Saturating counter with clear/enable, parameter LD_TIMEOUT.
  - Output: expired.
- Everything else is implemented inline.

## Test plan
- Reset mid-WAIT_LD (load to R3 waiting): rst pulse -> state IDLE, byp_pending=0, no write, retire_count=0.
- ALU back-to-back: 3 transfers (y=0x11, 0x22, 0x33 to R1, R2, R3) on consecutive cycles -> rf_we high for 3 consecutive cycles with matching data; in_ready stays 1; retire_count=3.
- Load with k=4: LD to R5, mem_rd=0xDEADBEEF arrives 4 cycles after accept -> in_ready low for 4 cycles; byp_pending=1 with byp_pend_addr=5 during the wait; then rf_we=1 with data 0xDEADBEEF.
- Zero-register and store suppression: JMP with rc=31 and pc=0x104 -> rf_we=0 but retire_count+1; ST -> rf_we=0 and retire_count+1.
- Load timeout (LD_TIMEOUT=15): load with mem_rd_valid never asserted -> after 15 wait cycles mem_err=1, no write, in_ready=1; mem_err stays 1 after the next ALU retire.
- Counter wrap (CNT_W=4): 17 retires -> retire_count=1.
